// File: rtl/riscv_mult_issue_pkg.sv
// rtl/riscv_mult_issue_pkg.sv - shared multiplier operator encodings, request struct and issue FSM states
package riscv_mult_issue_pkg;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_MSU32 = 3'b001;
  localparam logic [2:0] MUL_I     = 3'b010;
  localparam logic [2:0] MUL_IR    = 3'b011;
  localparam logic [2:0] MUL_DOT8  = 3'b100;
  localparam logic [2:0] MUL_DOT16 = 3'b101;
  localparam logic [2:0] MUL_H     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [2:0]  mul_op;
    logic        short_subword;
    logic [1:0]  short_signed;
    logic [1:0]  dot_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic [4:0]  imm;
    logic        is_clpx;
    logic        clpx_img;
    logic [1:0]  clpx_shift;
  } mult_req_t;

endpackage

// File: rtl/riscv_mult_issue.sv
// rtl/riscv_mult_issue.sv - request/response issue stage in front of the subword multiplier/MAC unit
module riscv_mult_issue
  import riscv_mult_issue_pkg::*;
#(
  parameter int unsigned MAX_BUSY_CYCLES = 8,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_operator_i,
  input  logic        req_short_subword_i,
  input  logic [1:0]  req_short_signed_i,
  input  logic [1:0]  req_dot_signed_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [31:0] req_op_c_i,
  input  logic [4:0]  req_imm_i,
  input  logic        req_is_clpx_i,
  input  logic        req_clpx_img_i,
  input  logic [1:0]  req_clpx_shift_i,
  output logic        mult_enable_o,
  output logic [2:0]  mult_operator_o,
  output logic        mult_short_subword_o,
  output logic [1:0]  mult_short_signed_o,
  output logic [1:0]  mult_dot_signed_o,
  output logic [31:0] mult_op_a_o,
  output logic [31:0] mult_op_b_o,
  output logic [31:0] mult_op_c_o,
  output logic [31:0] mult_dot_op_a_o,
  output logic [31:0] mult_dot_op_b_o,
  output logic [31:0] mult_dot_op_c_o,
  output logic [4:0]  mult_imm_o,
  output logic        mult_is_clpx_o,
  output logic        mult_clpx_img_o,
  output logic [1:0]  mult_clpx_shift_o,
  output logic        mult_ex_ready_o,
  input  logic [31:0] mult_result_i,
  input  logic        mult_ready_i,
  input  logic        mult_multicycle_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        error_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BUSY_CYCLES);

  issue_state_e         state_q, state_d;
  mult_req_t            req_q, req_d, req_in;
  logic [31:0]          result_q, result_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 kill_q, kill_d;
  logic                 error_q, error_d;
  logic                 unused_multicycle;

  // Multicycle status is only observed by the environment; the FSM keys off mult_ready_i.
  assign unused_multicycle = mult_multicycle_i;

  assign req_in = '{
    mul_op:        req_operator_i,
    short_subword: req_short_subword_i,
    short_signed:  req_short_signed_i,
    dot_signed:    req_dot_signed_i,
    op_a:          req_op_a_i,
    op_b:          req_op_b_i,
    op_c:          req_op_c_i,
    imm:           req_imm_i,
    is_clpx:       req_is_clpx_i,
    clpx_img:      req_clpx_img_i,
    clpx_shift:    req_clpx_shift_i
  };

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    result_d        = result_q;
    cnt_d           = cnt_q;
    kill_d          = kill_q;
    error_d         = error_q;
    req_ready_o     = 1'b0;
    mult_enable_o   = 1'b0;
    mult_ex_ready_o = 1'b0;
    rsp_valid_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !flush_i) begin
          req_d   = req_in;
          cnt_d   = '0;
          kill_d  = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mult_enable_o = 1'b1;
        // The MULH sequence cannot be aborted, so a flush only suppresses the response.
        if (flush_i) kill_d = 1'b1;
        if (mult_ready_i) begin
          result_d        = mult_result_i;
          mult_ex_ready_o = 1'b1;
          cnt_d           = '0;
          kill_d          = 1'b0;
          state_d         = (kill_q || flush_i) ? ST_IDLE : ST_DONE;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CNT_MAX) error_d = 1'b1;
      end
      ST_DONE: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (rsp_ready_i) begin
          if (req_valid_i) begin
            req_d   = req_in;
            cnt_d   = '0;
            kill_d  = 1'b0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      error_q  <= error_d;
    end
  end

  assign mult_operator_o      = req_q.mul_op;
  assign mult_short_subword_o = req_q.short_subword;
  assign mult_short_signed_o  = req_q.short_signed;
  assign mult_dot_signed_o    = req_q.dot_signed;
  assign mult_op_a_o          = req_q.op_a;
  assign mult_op_b_o          = req_q.op_b;
  assign mult_op_c_o          = req_q.op_c;
  assign mult_dot_op_a_o      = req_q.op_a;
  assign mult_dot_op_b_o      = req_q.op_b;
  assign mult_dot_op_c_o      = req_q.op_c;
  assign mult_imm_o           = req_q.imm;
  assign mult_is_clpx_o       = req_q.is_clpx;
  assign mult_clpx_img_o      = req_q.clpx_img;
  assign mult_clpx_shift_o    = req_q.clpx_shift;
  assign rsp_result_o         = result_q;
  assign error_o              = error_q;

endmodule
